// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage MIPS pipeline: load-use, branch flush,
// data-memory freeze and fetch wait, plus a fetch watchdog. Optional perf counters: HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ifid_instr,
  input  logic        i_idex_mem_read,
  input  logic [4:0]  i_idex_rt,
  input  logic        i_branch_taken,
  input  logic        i_imem_ready,
  input  logic        i_dmem_busy,
  output logic        o_pc_write,
  output logic        o_ifid_write,
  output logic        o_ifid_flush,
  output logic        o_idex_flush,
  output logic        o_pipe_hold,
  output logic [1:0]  o_ctrl_state,
  output logic        o_fetch_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STALL_LU   = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FETCH_WAIT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    A_FREEZE  = 3'd0,
    A_BRANCH  = 3'd1,
    A_LOADUSE = 3'd2,
    A_FWAIT   = 3'd3,
    A_NORMAL  = 3'd4
  } action_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_next_state;
  action_t     w_action;
  logic [7:0]  r_wait_cnt;
  logic        r_fetch_timeout;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_uses_rt;
  logic        w_load_use;

  // Decode the IF/ID instruction fields relevant to load-use detection.
  always_comb begin
    w_op = i_ifid_instr[31:26];
    w_rs = i_ifid_instr[25:21];
    w_rt = i_ifid_instr[20:16];
    case (w_op)
      6'b000000, 6'b000100, 6'b000101, 6'b101011: w_uses_rt = 1'b1;
      default:                                    w_uses_rt = 1'b0;
    endcase
    w_load_use = i_idex_mem_read && (i_idex_rt != 5'd0) &&
                 ((i_idex_rt == w_rs) || (w_uses_rt && (i_idex_rt == w_rt))) &&
                 (i_ifid_instr != 32'd0);
  end

  // Strict-priority action select; the stall state masks load-use for one cycle.
  always_comb begin
    w_action = A_NORMAL;
    if (i_dmem_busy) begin
      w_action = A_FREEZE;
    end else if (i_branch_taken) begin
      w_action = A_BRANCH;
    end else if (w_load_use && (r_state != ST_STALL_LU)) begin
      w_action = A_LOADUSE;
    end else if (!i_imem_ready) begin
      w_action = A_FWAIT;
    end else begin
      w_action = A_NORMAL;
    end
  end

  // Control outputs and next state per action; reset forces a nop/bubble.
  always_comb begin
    o_pc_write   = 1'b1;
    o_ifid_write = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_pipe_hold  = 1'b0;
    w_next_state = ST_RUN;
    if (i_rst) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
      o_pipe_hold  = 1'b0;
      w_next_state = ST_RUN;
    end else begin
      case (w_action)
        A_FREEZE: begin
          o_pc_write   = 1'b0;
          o_ifid_write = 1'b0;
          o_pipe_hold  = 1'b1;
          w_next_state = ST_MEM_WAIT;
        end
        A_BRANCH: begin
          o_ifid_flush = 1'b1;
          o_idex_flush = 1'b1;
          w_next_state = ST_RUN;
        end
        A_LOADUSE: begin
          o_pc_write   = 1'b0;
          o_ifid_write = 1'b0;
          o_idex_flush = 1'b1;
          w_next_state = ST_STALL_LU;
        end
        A_FWAIT: begin
          o_pc_write   = 1'b0;
          o_ifid_flush = 1'b1;
          w_next_state = ST_FETCH_WAIT;
        end
        A_NORMAL: begin
          w_next_state = ST_RUN;
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Fetch watchdog: saturating wait counter and sticky timeout flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt      <= 8'd0;
      r_fetch_timeout <= 1'b0;
    end else begin
      if (i_imem_ready) begin
        r_wait_cnt <= 8'd0;
      end else if ((w_action == A_FWAIT) && (r_wait_cnt != 8'hFF)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if ((w_action == A_FWAIT) && (r_wait_cnt == LP_WAIT_LAST)) begin
        r_fetch_timeout <= 1'b1;
      end else begin
        r_fetch_timeout <= r_fetch_timeout;
      end
    end
  end

  assign o_ctrl_state    = r_state;
  assign o_fetch_timeout = r_fetch_timeout;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Wrapping performance counters for stall and flush events.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      case (w_action)
        A_FREEZE, A_LOADUSE, A_FWAIT: r_stall_cnt <= r_stall_cnt + 32'd1;
        A_BRANCH:                     r_flush_cnt <= r_flush_cnt + 32'd1;
        default: begin
          r_stall_cnt <= r_stall_cnt;
          r_flush_cnt <= r_flush_cnt;
        end
      endcase
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule
